// File: rtl/mmio_store_fifo.sv
// Snoops CPU stores, captures aligned hits in a peripheral window and drains them FWFT over valid/ready.
// Optional: define MMIO_STORE_FIFO_DROP_CNT_EN to add a saturating drop_count output.
module mmio_store_fifo #(
   parameter int unsigned DEPTH       = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
   parameter int unsigned WINDOW_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_write,
   input  logic [31:0]              data_adr,
   input  logic [31:0]              write_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WINDOW_BITS-1:0]   out_offset,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
`ifdef MMIO_STORE_FIFO_DROP_CNT_EN
   ,
   output logic [15:0]              drop_count
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW:0]   CNT_FULL = DEPTH;

   typedef logic [WINDOW_BITS+31:0] entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        head;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          hit, empty, full, push, pop, drop;

   assign hit   = mem_write
                  && (data_adr[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS])
                  && (data_adr[1:0] == 2'b00);
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);
   assign pop   = out_ready && !empty;
   // A pop frees the slot in the same edge, so a full FIFO still accepts.
   assign push  = hit && (!full || pop);
   assign drop  = hit && full && !pop;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {data_adr[WINDOW_BITS-1:0], write_data};
   end

   assign head       = mem_q[rd_ptr_q];
   assign out_valid  = !empty;
   assign out_offset = empty ? '0 : head[WINDOW_BITS+31:32];
   assign out_data   = empty ? '0 : head[31:0];
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

`ifdef MMIO_STORE_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`endif

endmodule

// File: doc/mmio_store_fifo.md
Name: mmio_store_fifo

Overview:
- Sits directly downstream of the ARM core's data-memory write port.
- Snoops every store (MemWrite, DataAdr, WriteData) and captures those that fall inside a memory-mapped peripheral window.
- Buffers captured stores in order and drains them to a peripheral consumer (sprite/VGA register bank) over a valid/ready handshake.
- Decouples CPU store bursts from a slower consumer; overflow is flagged, never stalls the CPU.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2.
BASE_ADDR, 32'h0000_0400, window base; low WINDOW_BITS bits ignored.
WINDOW_BITS, 8, window size is 2^WINDOW_BITS bytes; range 2..16.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
mem_write  in  1  CPU store strobe.
data_adr  in  32  CPU store byte address.
write_data  in  32  CPU store data.
out_valid  out  1  head entry available.
out_ready  in  1  consumer accepts head this cycle.
out_offset  out  WINDOW_BITS  byte offset of head store within window.
out_data  out  32  data of head store.
fifo_count  out  $clog2(DEPTH)+1  entries currently held (0..DEPTH).
overflow  out  1  sticky: at least one in-window store was dropped.

Behaviour:
- Reset (reset=0, async): pointers, fifo_count, overflow cleared; out_valid=0, out_offset=0, out_data=0. Storage array need not be reset. Reset mid-burst discards all held entries; first store after release lands in an empty FIFO.
- Hit: mem_write=1 AND data_adr[31:WINDOW_BITS]==BASE_ADDR[31:WINDOW_BITS] AND data_adr[1:0]==2'b00.
- Misaligned in-window stores and out-of-window stores are ignored: not stored, no overflow.
- Sampling: inputs are sampled on the rising clk edge. One entry is captured per cycle with a hit.
- Capture latency: a hit at edge N makes the entry visible at the head after edge N (out_valid=1 in cycle N+1) when the FIFO was empty. No combinational path from mem_write to out_valid.
- Output timing: first-word-fall-through. out_offset and out_data reflect the head entry combinationally from storage whenever out_valid=1. Both read 0 when the FIFO is empty.
- out_valid = (fifo_count != 0).
- Pop: out_valid AND out_ready at an edge removes the head. out_ready is ignored while empty.
- Push: a hit at an edge writes {data_adr[WINDOW_BITS-1:0], write_data} at the tail when not full.
- Full (fifo_count==DEPTH) with pop in the same cycle: push is accepted, fifo_count stays DEPTH.
- Full without pop: hit is dropped, overflow set to 1 on that edge. overflow is cleared only by reset.
- Empty with simultaneous hit: no pop occurs; count becomes 1.
- Simultaneous push and pop (non-empty, non-full): count unchanged, order preserved.
- Ordering: strict FIFO; entries leave in the CPU's store order.
- Pointers: log2(DEPTH)-bit read/write pointers wrapping modulo DEPTH. fifo_count is a separate counter with saturating-free exact update: +1 push only, -1 pop only, 0 both/neither.

Optional Feature:
- Macro: MMIO_STORE_FIFO_DROP_CNT_EN.
- Defined: adds output drop_count [15:0]. It increments by 1 on each dropped hit, saturates at 16'hFFFF and resets to 0. overflow behaves as drop_count != 0 but remains its own sticky flop.
- Undefined: no drop_count port, no counter logic; all other behaviour identical.

Test Plan:
- Store to 0x404 data 7, out_ready=0 -> next cycle out_valid=1, out_offset=8'h04, out_data=7, fifo_count=1. Raise out_ready one cycle -> out_valid=0, count=0.
- Stores to 0x64 (data 7), 0x60, and misaligned 0x402 -> out_valid stays 0, fifo_count=0, overflow=0.
- out_ready=0, 8 stores to 0x400..0x41C (data 1..8), then a 9th to 0x420 (data 9) -> count=8, overflow=1, drain yields data 1..8 in order, data 9 absent. With the macro defined, drop_count=1.
- FIFO full, same-cycle store to 0x430 (data 0xAA) with out_ready=1 -> count stays 8, overflow=0, 0xAA is the last entry drained.
- Back-to-back stores every cycle with out_ready=1 continuously -> each entry appears exactly one cycle after capture, count never exceeds 1, data order matches.
- Load 5 entries, assert reset=0 mid-cycle (asynchronous) -> out_valid=0, count=0, overflow=0 immediately. After release, store 0x408 data 3 -> head is offset 8'h08, data 3.
